ar_rx_word: RTL and testbench

Receive-side word assembler for the ARINC-429 loop. It consumes the bipolar comparator outputs RXP/RXN, which the threshold stage derives from the ADC samples. It qualifies each return-to-zero pulse by width, shifts 32 bits into a word, checks odd parity, and frames words on the inter-word null gap. Its outputs are the assembled word, a one-cycle `valid` strobe, error strobes and a received-word counter, which feed the display multiplexer and the error LED.

---
 rtl/ar_rx_word_if.sv | 22 ++
 rtl/ar_rx_word.sv | 198 +++++++++++++++++++
 tb/tb_ar_rx_word.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ar_rx_word_if.sv
// ARINC-429 receive word assembler bus: line inputs with sampling tick,
// and the assembled-word outputs towards display mux / error LED.
interface ar_rx_word_if;
  logic        ce;
  logic        RXP;
  logic        RXN;
  logic [31:0] dat;
  logic        valid;
  logic        par_ok;
  logic        err;
  logic [7:0]  N_word;

  modport master (
    output ce, RXP, RXN,
    input  dat, valid, par_ok, err, N_word
  );

  modport slave (
    input  ce, RXP, RXN,
    output dat, valid, par_ok, err, N_word
  );
endinterface

// File: rtl/ar_rx_word.sv
// ARINC-429 receive word assembler: qualifies RZ pulses by width, shifts
// 32 bits LSB first, frames on the inter-word null gap, checks odd parity.
module ar_rx_word #(
  parameter int MIN_W     = 3,
  parameter int MAX_W     = 8,
  parameter int GAP_TICKS = 40
) (
  input logic         clk,
  input logic         rst,
  ar_rx_word_if.slave bus
);

  typedef enum logic [1:0] {SYNC, IDLE, PULSE, GAPW} state_t;

  localparam logic [7:0] P_MIN = 8'(MIN_W);
  localparam logic [7:0] P_MAX = 8'(MAX_W);
  localparam logic [7:0] P_GAP = 8'(GAP_TICKS);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_wcnt;
  logic [7:0]  r_ncnt;
  logic [5:0]  r_bcnt;
  logic        r_pol;
  logic [31:0] r_shreg;
  logic [31:0] r_dat;
  logic        r_valid;
  logic        r_par_ok;
  logic        r_err;
  logic [7:0]  r_nword;

  logic        w_null;
  logic        w_ill;
  logic        w_one;
  logic        w_zero;
  logic        w_pulse;
  logic        w_same;
  logic [7:0]  w_ninc;
  logic        w_gap_hit;
  logic        w_short;
  logic        w_over;
  logic        w_full;

  logic        w_err;
  logic        w_pub;
  logic        w_accept;
  logic        w_pstart;

  // Line-state decode and counter comparisons shared by both FSM processes
  assign w_null    = !bus.RXP && !bus.RXN;
  assign w_ill     =  bus.RXP &&  bus.RXN;
  assign w_one     =  bus.RXP && !bus.RXN;
  assign w_zero    = !bus.RXP &&  bus.RXN;
  assign w_pulse   = w_one || w_zero;
  assign w_same    = w_pulse && (w_one == r_pol);
  assign w_ninc    = (r_ncnt == 8'hFF) ? r_ncnt : r_ncnt + 8'd1;
  assign w_gap_hit = (w_ninc >= P_GAP);
  assign w_short   = (r_wcnt < P_MIN);
  assign w_over    = (r_wcnt >= P_MAX);   // one more tick would exceed MAX_W
  assign w_full    = (r_bcnt == 6'd32);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= SYNC;
    else     r_state <= w_state_nxt;
  end

  // Next-state decision, evaluated only on ce ticks
  always_comb begin
    w_state_nxt = r_state;
    if (bus.ce) begin
      case (r_state)
        SYNC: begin
          if (w_null && w_gap_hit) w_state_nxt = IDLE;
        end
        IDLE: begin
          if (w_pulse)    w_state_nxt = PULSE;
          else if (w_ill) w_state_nxt = SYNC;
        end
        PULSE: begin
          if (w_null)      w_state_nxt = w_short ? SYNC : GAPW;
          else if (w_same) w_state_nxt = w_over ? SYNC : PULSE;
          else             w_state_nxt = SYNC;
        end
        GAPW: begin
          if (w_null) begin
            if (w_gap_hit) w_state_nxt = IDLE;
          end else if (w_pulse) begin
            w_state_nxt = w_full ? SYNC : PULSE;
          end else begin
            w_state_nxt = SYNC;
          end
        end
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  // Per-tick actions: error, publish, bit accept, pulse start
  always_comb begin
    w_err    = 1'b0;
    w_pub    = 1'b0;
    w_accept = 1'b0;
    w_pstart = 1'b0;
    if (bus.ce) begin
      case (r_state)
        IDLE: begin
          if (w_pulse)    w_pstart = 1'b1;
          else if (w_ill) w_err    = 1'b1;
        end
        PULSE: begin
          if (w_null) begin
            if (w_short) w_err    = 1'b1;
            else         w_accept = 1'b1;
          end else if (w_same) begin
            if (w_over) w_err = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        GAPW: begin
          if (w_null) begin
            if (w_gap_hit) begin
              if (w_full) w_pub = 1'b1;
              else        w_err = 1'b1;
            end
          end else if (w_pulse) begin
            if (w_full) w_err    = 1'b1;
            else        w_pstart = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Counters, shift register and published outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt   <= '0;
      r_ncnt   <= '0;
      r_bcnt   <= '0;
      r_pol    <= 1'b0;
      r_shreg  <= '0;
      r_dat    <= '0;
      r_valid  <= 1'b0;
      r_par_ok <= 1'b0;
      r_err    <= 1'b0;
      r_nword  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (bus.ce) begin
        r_valid <= w_pub;
        r_err   <= w_err;

        // The null sample that ends a pulse already counts as null tick 1
        case (r_state)
          SYNC, GAPW: r_ncnt <= w_null ? w_ninc : '0;
          IDLE:       if (!w_null) r_ncnt <= '0;
          PULSE:      r_ncnt <= w_null ? 8'd1 : '0;
          default:    r_ncnt <= '0;
        endcase

        if (w_pstart) begin
          r_wcnt <= 8'd1;
          r_pol  <= w_one;
        end else if (r_state == PULSE && w_same) begin
          r_wcnt <= r_wcnt + 8'd1;
        end

        // Any entry to SYNC or IDLE discards the partial word
        if (w_accept) begin
          r_shreg[r_bcnt[4:0]] <= r_pol;
          r_bcnt               <= r_bcnt + 6'd1;
        end else if (w_state_nxt == SYNC || w_state_nxt == IDLE) begin
          r_bcnt <= '0;
        end

        if (w_pub) begin
          r_dat    <= r_shreg;
          r_par_ok <= ^r_shreg;
          r_nword  <= r_nword + 8'd1;
        end
      end
    end
  end

  assign bus.dat    = r_dat;
  assign bus.valid  = r_valid;
  assign bus.par_ok = r_par_ok;
  assign bus.err    = r_err;
  assign bus.N_word = r_nword;

endmodule

// File: tb/tb_ar_rx_word.sv
// Self-checking bench for ar_rx_word: word-level reference model with
// randomized words, pulse widths, in-word nulls and ce spacing.
`timescale 1ns/1ps
module tb_ar_rx_word;

  localparam int MIN_W = 3;
  localparam int MAX_W = 8;
  localparam int GAP   = 40;

  logic clk = 1'b0;
  logic rst;

  ar_rx_word_if bus ();

  ar_rx_word #(.MIN_W(MIN_W), .MAX_W(MAX_W), .GAP_TICKS(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_mis = 0;
  int unsigned n_valid = 0;
  int unsigned n_err = 0;
  int unsigned n_both = 0;
  int unsigned gap_max = 2;

  // Word-level model of what the outputs must hold
  logic [31:0] exp_dat = '0;
  logic        exp_par = 1'b0;
  logic [7:0]  exp_n   = '0;

  always @(negedge clk) begin
    if (bus.valid) n_valid++;
    if (bus.err) n_err++;
    if (bus.valid && bus.err) n_both++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic model_publish(input logic [31:0] w);
    exp_dat = w;
    exp_par = ^w;
    exp_n   = exp_n + 8'd1;
  endtask

  task automatic tick(input logic p, input logic n);
    bus.RXP = p;
    bus.RXN = n;
    bus.ce  = 1'b1;
    @(negedge clk);
    bus.ce  = 1'b0;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
  endtask

  task automatic send_pulse(input logic b, input int unsigned w);
    repeat (w) tick(b, ~b);
  endtask

  task automatic send_null(input int unsigned n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  function automatic int unsigned rand_null();
    return ($urandom_range(0, 19) == 0) ? GAP - 1 : $urandom_range(1, 8);
  endfunction

  task automatic send_bits(input logic [31:0] w, input int n, input bit fast);
    for (int i = 0; i < n; i++) begin
      send_pulse(w[i], fast ? MIN_W : $urandom_range(MIN_W, MAX_W));
      if (i < n - 1) send_null(fast ? 1 : rand_null());
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit fast);
    send_bits(w, 32, fast);
    send_null(GAP);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.dat !== 32'h0) begin n_mis++; $display("FAIL reset_dat: got %h want 0", bus.dat); end
    n_cmp++; if (bus.valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    n_cmp++; if (bus.par_ok !== 1'b0) begin n_mis++; $display("FAIL reset_par_ok: got %b want 0", bus.par_ok); end
    n_cmp++; if (bus.err !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.N_word !== 8'h0) begin n_mis++; $display("FAIL reset_nword: got %0d want 0", bus.N_word); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int unsigned v0, e0;
    logic [31:0] words [2];
    words[0] = 32'h800000A5;
    words[1] = 32'h000000A5;
    send_null(GAP);
    for (int k = 0; k < 2; k++) begin
      v0 = n_valid; e0 = n_err;
      send_word(words[k], 1'b0);
      model_publish(words[k]);
      settle();
      n_cmp++; if (n_valid - v0 !== 1) begin n_mis++; $display("FAIL basic_valid[%0d]: got %0d strobes want 1", k, n_valid - v0); end
      n_cmp++; if (n_err - e0 !== 0) begin n_mis++; $display("FAIL basic_err[%0d]: got %0d strobes want 0", k, n_err - e0); end
      n_cmp++; if (bus.dat !== exp_dat) begin n_mis++; $display("FAIL basic_dat[%0d]: got %h want %h", k, bus.dat, exp_dat); end
      n_cmp++; if (bus.par_ok !== exp_par) begin n_mis++; $display("FAIL basic_par_ok[%0d]: got %b want %b", k, bus.par_ok, exp_par); end
      n_cmp++; if (bus.N_word !== exp_n) begin n_mis++; $display("FAIL basic_nword[%0d]: got %0d want %0d", k, bus.N_word, exp_n); end
    end
  endtask

  task automatic test_random_words();
    int unsigned v0, e0;
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      w = $urandom;
      v0 = n_valid; e0 = n_err;
      send_word(w, 1'b0);
      model_publish(w);
      settle();
      n_cmp++; if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin n_mis++; $display("FAIL rand_strobes[%0d]: got valid %0d err %0d want 1 0", k, n_valid - v0, n_err - e0); end
      n_cmp++; if (bus.dat !== exp_dat) begin n_mis++; $display("FAIL rand_dat[%0d]: got %h want %h", k, bus.dat, exp_dat); end
      n_cmp++; if (bus.par_ok !== exp_par) begin n_mis++; $display("FAIL rand_par_ok[%0d]: got %b want %b", k, bus.par_ok, exp_par); end
      n_cmp++; if (bus.N_word !== exp_n) begin n_mis++; $display("FAIL rand_nword[%0d]: got %0d want %0d", k, bus.N_word, exp_n); end
    end
  endtask

  task automatic test_glitch();
    int unsigned v0, e0;
    logic [31:0] w;
    v0 = n_valid; e0 = n_err;
    send_bits($urandom, 5, 1'b0);
    send_null(2);
    send_pulse(1'b0, MIN_W - 1);
    send_null(GAP + 1);
    settle();
    n_cmp++; if (n_err - e0 !== 1) begin n_mis++; $display("FAIL glitch_err: got %0d strobes want 1", n_err - e0); end
    n_cmp++; if (n_valid - v0 !== 0) begin n_mis++; $display("FAIL glitch_valid: got %0d strobes want 0", n_valid - v0); end
    n_cmp++; if (bus.dat !== exp_dat || bus.N_word !== exp_n) begin n_mis++; $display("FAIL glitch_hold: got %h/%0d want %h/%0d", bus.dat, bus.N_word, exp_dat, exp_n); end
    w = $urandom;
    send_word(w, 1'b0);
    model_publish(w);
    settle();
    n_cmp++; if (bus.dat !== exp_dat || n_valid - v0 !== 1) begin n_mis++; $display("FAIL glitch_recover: got %h valid %0d want %h valid 1", bus.dat, n_valid - v0, exp_dat); end
  endtask

  task automatic test_short_and_long_word();
    int unsigned v0, e0;
    logic [31:0] w;
    v0 = n_valid; e0 = n_err;
    send_bits($urandom, 20, 1'b0);
    send_null(GAP);
    settle();
    n_cmp++; if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin n_mis++; $display("FAIL short_word: got err %0d valid %0d want 1 0", n_err - e0, n_valid - v0); end
    n_cmp++; if (bus.dat !== exp_dat || bus.N_word !== exp_n) begin n_mis++; $display("FAIL short_hold: got %h/%0d want %h/%0d", bus.dat, bus.N_word, exp_dat, exp_n); end
    // Short-word error leaves the receiver idle, so a word may follow directly
    w = $urandom;
    send_word(w, 1'b0);
    model_publish(w);
    settle();
    n_cmp++; if (bus.dat !== exp_dat || n_valid - v0 !== 1) begin n_mis++; $display("FAIL short_next: got %h valid %0d want %h valid 1", bus.dat, n_valid - v0, exp_dat); end

    v0 = n_valid; e0 = n_err;
    send_bits($urandom, 32, 1'b0);
    send_null(3);
    send_pulse(1'b1, 5);
    send_null(5);
    send_word($urandom, 1'b0);  // no preceding gap: must not be published
    settle();
    n_cmp++; if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin n_mis++; $display("FAIL long_word: got err %0d valid %0d want 1 0", n_err - e0, n_valid - v0); end
    n_cmp++; if (bus.dat !== exp_dat || bus.N_word !== exp_n) begin n_mis++; $display("FAIL long_hold: got %h/%0d want %h/%0d", bus.dat, bus.N_word, exp_dat, exp_n); end
    w = $urandom;
    send_word(w, 1'b0);
    model_publish(w);
    settle();
    n_cmp++; if (bus.dat !== exp_dat || n_valid - v0 !== 1 || n_err - e0 !== 1) begin n_mis++; $display("FAIL long_next: got %h valid %0d err %0d want %h 1 1", bus.dat, n_valid - v0, n_err - e0, exp_dat); end
  endtask

  task automatic test_ill_and_wide();
    int unsigned v0, e0;
    logic [31:0] w;
    v0 = n_valid; e0 = n_err;
    send_bits($urandom, 4, 1'b0);
    send_null(2);
    send_pulse(1'b1, 2);
    tick(1'b1, 1'b1);
    send_pulse(1'b1, 2);
    send_null(GAP + 1);
    settle();
    n_cmp++; if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin n_mis++; $display("FAIL ill_pulse: got err %0d valid %0d want 1 0", n_err - e0, n_valid - v0); end
    w = $urandom;
    send_word(w, 1'b0);
    model_publish(w);
    settle();
    n_cmp++; if (bus.dat !== exp_dat || n_valid - v0 !== 1) begin n_mis++; $display("FAIL ill_recover: got %h valid %0d want %h 1", bus.dat, n_valid - v0, exp_dat); end

    v0 = n_valid; e0 = n_err;
    send_bits($urandom, 3, 1'b0);
    send_null(2);
    send_pulse(1'b0, MAX_W + 1);
    send_null(GAP + 1);
    settle();
    n_cmp++; if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin n_mis++; $display("FAIL wide_pulse: got err %0d valid %0d want 1 0", n_err - e0, n_valid - v0); end
    n_cmp++; if (bus.dat !== exp_dat || bus.N_word !== exp_n) begin n_mis++; $display("FAIL wide_hold: got %h/%0d want %h/%0d", bus.dat, bus.N_word, exp_dat, exp_n); end
    w = $urandom;
    send_bits(w, 32, 1'b0);
    send_pulse(1'b1, MAX_W);  // widest legal pulse is not an error here
    send_null(1);
    send_null(GAP);
    settle();
    n_cmp++; if (n_err - e0 !== 2 || n_valid - v0 !== 0) begin n_mis++; $display("FAIL wide_max_long: got err %0d valid %0d want 2 0", n_err - e0, n_valid - v0); end
  endtask

  task automatic test_wrap();
    int unsigned v0;
    int rem;
    logic [31:0] w;
    gap_max = 0;
    send_null(GAP + 1);
    rem = 256 - int'(exp_n);
    v0 = n_valid;
    for (int k = 0; k < rem; k++) begin
      w = $urandom;
      send_word(w, 1'b1);
      model_publish(w);
    end
    settle();
    n_cmp++; if (bus.N_word !== 8'd0) begin n_mis++; $display("FAIL wrap_nword: got %0d want 0", bus.N_word); end
    n_cmp++; if (n_valid - v0 !== rem) begin n_mis++; $display("FAIL wrap_valid: got %0d strobes want %0d", n_valid - v0, rem); end
    n_cmp++; if (bus.dat !== exp_dat || bus.par_ok !== exp_par) begin n_mis++; $display("FAIL wrap_dat: got %h/%b want %h/%b", bus.dat, bus.par_ok, exp_dat, exp_par); end
    gap_max = 2;
  endtask

  task automatic test_reset_midword();
    int unsigned v0, e0;
    logic [31:0] w;
    send_bits($urandom, 10, 1'b0);
    send_null(2);
    send_pulse(1'b1, 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    exp_dat = '0; exp_par = 1'b0; exp_n = '0;
    n_cmp++; if (bus.dat !== exp_dat || bus.par_ok !== 1'b0 || bus.N_word !== exp_n) begin n_mis++; $display("FAIL midrst_outputs: got %h/%b/%0d want 0/0/0", bus.dat, bus.par_ok, bus.N_word); end
    n_cmp++; if (bus.valid !== 1'b0 || bus.err !== 1'b0) begin n_mis++; $display("FAIL midrst_strobes: got %b/%b want 0/0", bus.valid, bus.err); end
    rst = 1'b0;
    v0 = n_valid; e0 = n_err;
    send_pulse(1'b1, 3);
    send_null(2);
    send_bits($urandom, 21, 1'b0);
    send_null(GAP);
    settle();
    n_cmp++; if (n_valid - v0 !== 0 || n_err - e0 !== 0 || bus.N_word !== 8'd0) begin n_mis++; $display("FAIL midrst_tail: got valid %0d err %0d nword %0d want 0 0 0", n_valid - v0, n_err - e0, bus.N_word); end
    w = $urandom;
    send_word(w, 1'b0);
    model_publish(w);
    settle();
    n_cmp++; if (bus.dat !== exp_dat || bus.par_ok !== exp_par || bus.N_word !== exp_n) begin n_mis++; $display("FAIL midrst_next: got %h/%b/%0d want %h/%b/%0d", bus.dat, bus.par_ok, bus.N_word, exp_dat, exp_par, exp_n); end
  endtask

  initial begin
    rst     = 1'b1;
    bus.ce  = 1'b0;
    bus.RXP = 1'b0;
    bus.RXN = 1'b0;
    test_reset();
    test_basic();
    test_random_words();
    test_glitch();
    test_short_and_long_word();
    test_ill_and_wide();
    test_wrap();
    test_reset_midword();
    n_cmp++; if (n_both !== 0) begin n_mis++; $display("FAIL valid_err_overlap: got %0d cycles want 0", n_both); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
